ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-client controller for the 64 x 8 simple dual-port block RAM: it clears the RAM after reset, then shares the RAM's write port (A) and read port (B) between two requesters. Each port has its own round-robin arbiter and a valid/ready request handshake. Read data is routed back to the requester that issued the read. The block sits between the RAM writer/reader clients and the block-RAM instance, and drives every RAM port signal itself.

## Interface
- `ADDR_W`, default 6: RAM address width (depth 2^ADDR_W).
- `DATA_W`, default 8: RAM data width.
- `RD_LAT`, default 1: block-RAM read latency in cycles, legal values 1..2.
- `INIT_EN`, default 1: when 1, zero-fill the RAM after reset; when 0, skip the fill.
- `sys_clk` in 1: single clock for all logic and both RAM ports.
- `sys_rst` in 1: reset, synchronous, active-high.
- `c_req_valid` in 2: per-client request valid; bit i belongs to client i.
- `c_req_we` in 2: per-client request type; 1 = write, 0 = read.
- `c_req_addr` in 2*ADDR_W: client i address in slice [i*ADDR_W +: ADDR_W].
- `c_req_wdata` in 2*DATA_W: client i write data in slice [i*DATA_W +: DATA_W].
- `c_req_ready` out 2: request accepted when valid and ready are both high at the clock edge.
- `c_rsp_valid` out 2: one-cycle pulse marking that read data for client i is on `c_rsp_rdata`.
- `c_rsp_rdata` out DATA_W: shared read-data bus, qualified by `c_rsp_valid`.
- `init_done` out 1: high once the zero-fill is complete; stays high until the next reset.
- `ram_wr_en`, `ram_wr_we` out 1: RAM port A enable and write enable.
- `ram_wr_addr` out ADDR_W, `ram_wr_data` out DATA_W: RAM port A address and data.
- `ram_rd_en` out 1, `ram_rd_addr` out ADDR_W: RAM port B enable and address.
- `ram_rd_data` in DATA_W: RAM port B data output.

## Operation
- **FSM states:** INIT, RUN.
- **Reset value of every output:** 0. After reset the FSM is in INIT with the fill counter at 0.
- **INIT (INIT_EN=1):**
  - Each cycle: write 0 to address `fill_cnt`, with `ram_wr_en` = `ram_wr_we` = 1.
  - `fill_cnt` increments by 1 per cycle.
  - When `fill_cnt` = 2^ADDR_W-1 the counter wraps to 0 and the FSM moves to RUN.
  - `c_req_ready` = 0 throughout INIT.
- **INIT_EN=0:** the FSM moves INIT→RUN on the first cycle after reset and performs no writes.
- **RUN:** `init_done` = 1. The write arbiter considers clients with valid=1 and we=1; the read arbiter considers clients with valid=1 and we=0.
- **Round-robin rule (each arbiter independently):**
  - A single requester is granted.
  - With two requesters, the client holding the priority pointer is granted.
  - After any grant, the pointer moves to the other client.
  - Both pointers reset to client 0.
- **Ready:** `c_req_ready[i]` = RUN and granted by its arbiter. It is combinational from `c_req_valid`, `c_req_we` and `c_req_addr`.
- **Same-cycle address conflict:** if the read winner's address equals the write winner's address in the same cycle, the read grant is withheld. That client's ready stays 0 and the read pointer does not move. The read is granted in a later cycle and returns the new data.
- **Issue:** accepted requests are registered onto the RAM ports in the next cycle.
  - `ram_wr_en` and `ram_wr_we` are high for exactly one cycle per accepted write; the same applies to `ram_rd_en` per accepted read.
  - Address and data outputs hold their last value while the enables are low.
- **Return:** a tag shift register of depth RD_LAT carries the issuing client id alongside each read. `c_rsp_valid[id]` pulses when the data emerges.
- **No backpressure on responses:** the client must sink data in the cycle it is presented.
- **Reset mid-operation:**
  - Pending tags are cleared and in-flight responses are dropped; no `c_rsp_valid` is produced for them.
  - Both pointers return to client 0.
  - The INIT zero-fill is redone.

## Timing
- **Zero-fill:** with INIT_EN=1, writes occupy cycles 1..2^ADDR_W after reset release. `init_done` rises in the cycle after the last write: cycle 65 for the default ADDR_W=6.
- **Write:** accepted at edge t; `ram_wr_en`/`ram_wr_we` are high in cycle t+1.
- **Read:** accepted at edge t; `ram_rd_en` is high in cycle t+1; `c_rsp_valid` and `c_rsp_rdata` are valid in cycle t+1+RD_LAT.
- **Throughput:** one write and one read per cycle, to different addresses.
- **Write-then-read:** a read accepted one or more cycles after a write to the same address returns the written data.

## Structure
- **Package `ram_arb_pkg`:**
  - `NUM_CLIENTS` = 2.
  - State enum {INIT, RUN}.
  - `RD_LAT` legal-range constants.
- **Sub-module `rr_arb2`:** 2-way round-robin arbiter with request vector, grant vector, update-enable and pointer register. It is instantiated once for writes and once for reads.
- The top level contains the FSM, fill counter, conflict compare, port registers and the tag pipeline.

## Test plan
- **Zero-fill check:** reset with INIT_EN=1 → 64 consecutive zero writes to addresses 0..63; `init_done` rises in cycle 65; then reading address 37 returns 0x00.
- **Write-port contention:** both clients hold a write request for 4 cycles (c0 to addr 5, c1 to addr 6) → grants alternate c0,c1,c0,c1; the RAM sees 4 writes in sequence.
- **Simultaneous read and write:** c0 writes 0xA5 to addr 3 while c1 reads addr 9, same cycle → both are accepted; c1 receives the previous contents of addr 9 at t+1+RD_LAT.
- **Address conflict:** c0 writes 0x3C to addr 12 while c1 reads addr 12 in the same cycle → c1's ready is 0 that cycle; the read is accepted the next cycle and returns 0x3C.
- **Latency with RD_LAT=2:** back-to-back reads by c0 then c1 → `c_rsp_valid[0]` pulses at t+3 and `c_rsp_valid[1]` at t+4, each with the correct data.
- **Reset mid-operation:** assert `sys_rst` for 1 cycle while a read is in flight → no `c_rsp_valid` for that read; all outputs go to 0; the zero-fill restarts from address 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client block-RAM port arbiter.
package ram_arb_pkg;

   // Number of requesting clients sharing the RAM ports.
   localparam int NUM_CLIENTS = 2;

   // Supported block-RAM read latencies (cycles from port-B enable to data).
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Controller state: zero-fill after reset, then normal arbitration.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// client holding the pointer wins. The pointer flips to the other client
// after every grant that the parent commits through upd_i.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_CLIENTS-1:0] req_i,
   input  logic                   upd_i,
   output logic [NUM_CLIENTS-1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // Grant selection: pass a single request through, break ties with the pointer.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // Pointer update: after a committed grant, favour the client that lost.
   always_comb begin
      ptr_d = ptr_q;
      if (upd_i && (gnt_o != 2'b00)) begin
         ptr_d = gnt_o[0];
      end
   end

   // Pointer register, back to client 0 on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client controller for a simple dual-port block RAM. Zero-fills the RAM
// after reset, then arbitrates the write port and read port independently,
// registers accepted requests onto the RAM ports and routes read data back
// to the issuing client through a tag pipeline matched to the read latency.
//
// Handshake: a request from client i is taken when c_req_valid[i] and
// c_req_ready[i] are both high at a rising clock edge; ready is combinational
// from the request inputs and may drop or rise in any cycle. Responses are a
// one-cycle c_rsp_valid pulse with no backpressure.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1,
   parameter int INIT_EN = 1
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [NUM_CLIENTS-1:0]        c_req_valid,
   input  logic [NUM_CLIENTS-1:0]        c_req_we,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] c_req_addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0] c_req_wdata,
   output logic [NUM_CLIENTS-1:0]        c_req_ready,
   output logic [NUM_CLIENTS-1:0]        c_rsp_valid,
   output logic [DATA_W-1:0]             c_rsp_rdata,
   output logic                          init_done,
   output logic                          ram_wr_en,
   output logic                          ram_wr_we,
   output logic [ADDR_W-1:0]             ram_wr_addr,
   output logic [DATA_W-1:0]             ram_wr_data,
   output logic                          ram_rd_en,
   output logic [ADDR_W-1:0]             ram_rd_addr,
   input  logic [DATA_W-1:0]             ram_rd_data
);

   // Out-of-range latencies are clamped into the supported window.
   localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                        (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   localparam logic [ADDR_W-1:0] FILL_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] FILL_LAST = {ADDR_W{1'b1}};

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       fill_cnt_q, fill_cnt_d;
   logic                    init_done_q;

   logic [NUM_CLIENTS-1:0]  wr_req, rd_req;
   logic [NUM_CLIENTS-1:0]  wr_gnt, rd_gnt;
   logic [NUM_CLIENTS-1:0]  wr_acc, rd_acc;
   logic [ADDR_W-1:0]       wr_win_addr, rd_win_addr;
   logic [DATA_W-1:0]       wr_win_data;
   logic                    run;
   logic                    conflict;

   logic                    ram_wr_en_q, ram_wr_en_d;
   logic [ADDR_W-1:0]       ram_wr_addr_q, ram_wr_addr_d;
   logic [DATA_W-1:0]       ram_wr_data_q, ram_wr_data_d;
   logic                    ram_rd_en_q, ram_rd_en_d;
   logic [ADDR_W-1:0]       ram_rd_addr_q, ram_rd_addr_d;

   // Stage 0 lines up with ram_rd_en; stage LAT lines up with ram_rd_data.
   logic [LAT:0]            tag_vld_q, tag_vld_d;
   logic [LAT:0]            tag_id_q, tag_id_d;

   assign run    = (state_q == RUN);
   assign wr_req = c_req_valid & c_req_we;
   assign rd_req = c_req_valid & ~c_req_we;

   rr_arb2 u_wr_arb (
      .clk_i (sys_clk),
      .rst_i (sys_rst),
      .req_i (wr_req),
      .upd_i (run),
      .gnt_o (wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk_i (sys_clk),
      .rst_i (sys_rst),
      .req_i (rd_req),
      .upd_i (run && !conflict),
      .gnt_o (rd_gnt)
   );

   // Winner address/data muxes and the same-address read/write conflict compare.
   always_comb begin
      wr_win_addr = wr_gnt[1] ? c_req_addr[ADDR_W +: ADDR_W]  : c_req_addr[0 +: ADDR_W];
      wr_win_data = wr_gnt[1] ? c_req_wdata[DATA_W +: DATA_W] : c_req_wdata[0 +: DATA_W];
      rd_win_addr = rd_gnt[1] ? c_req_addr[ADDR_W +: ADDR_W]  : c_req_addr[0 +: ADDR_W];
      conflict    = (wr_gnt != 2'b00) && (rd_gnt != 2'b00) && (wr_win_addr == rd_win_addr);
      wr_acc      = run ? wr_gnt : 2'b00;
      rd_acc      = (run && !conflict) ? rd_gnt : 2'b00;
      c_req_ready = wr_acc | rd_acc;
   end

   // Next state: INIT walks the fill counter (or leaves at once when fill is off).
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      case (state_q)
         INIT: begin
            if (INIT_EN != 0) begin
               fill_cnt_d = fill_cnt_q + FILL_ONE;
               if (fill_cnt_q == FILL_LAST) begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Next RAM port values: fill writes in INIT, accepted requests in RUN.
   always_comb begin
      ram_wr_en_d   = 1'b0;
      ram_wr_addr_d = ram_wr_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      ram_rd_en_d   = 1'b0;
      ram_rd_addr_d = ram_rd_addr_q;
      if (state_q == INIT) begin
         if (INIT_EN != 0) begin
            ram_wr_en_d   = 1'b1;
            ram_wr_addr_d = fill_cnt_q;
            ram_wr_data_d = '0;
         end
      end else if (wr_acc != 2'b00) begin
         ram_wr_en_d   = 1'b1;
         ram_wr_addr_d = wr_win_addr;
         ram_wr_data_d = wr_win_data;
      end
      if (rd_acc != 2'b00) begin
         ram_rd_en_d   = 1'b1;
         ram_rd_addr_d = rd_win_addr;
      end
   end

   // Tag pipeline: shift the issuing client id along with each read.
   always_comb begin
      tag_vld_d = {tag_vld_q[LAT-1:0], (rd_acc != 2'b00)};
      tag_id_d  = {tag_id_q[LAT-1:0], rd_acc[1]};
   end

   // State, counter, RAM port and tag registers; reset clears all of them.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= INIT;
         fill_cnt_q    <= '0;
         init_done_q   <= 1'b0;
         ram_wr_en_q   <= 1'b0;
         ram_wr_addr_q <= '0;
         ram_wr_data_q <= '0;
         ram_rd_en_q   <= 1'b0;
         ram_rd_addr_q <= '0;
         tag_vld_q     <= '0;
         tag_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         fill_cnt_q    <= fill_cnt_d;
         init_done_q   <= (state_q == RUN);
         ram_wr_en_q   <= ram_wr_en_d;
         ram_wr_addr_q <= ram_wr_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         ram_rd_en_q   <= ram_rd_en_d;
         ram_rd_addr_q <= ram_rd_addr_d;
         tag_vld_q     <= tag_vld_d;
         tag_id_q      <= tag_id_d;
      end
   end

   // Response routing: data is qualified by the tag leaving the pipeline.
   always_comb begin
      c_rsp_valid = 2'b00;
      c_rsp_rdata = '0;
      if (tag_vld_q[LAT]) begin
         c_rsp_valid[tag_id_q[LAT]] = 1'b1;
         c_rsp_rdata                = ram_rd_data;
      end
   end

   assign init_done   = init_done_q;
   assign ram_wr_en   = ram_wr_en_q;
   assign ram_wr_we   = ram_wr_en_q;
   assign ram_wr_addr = ram_wr_addr_q;
   assign ram_wr_data = ram_wr_data_q;
   assign ram_rd_en   = ram_rd_en_q;
   assign ram_rd_addr = ram_rd_addr_q;

endmodule
